uart_cmd_slv: RTL and testbench

//  DSO-side end of the host UART command link. Deserialises 3 bytes from RX into a 24-bit command.

---
 rtl/uart_cmd_slv.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cmd_slv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_slv.sv
// uart_cmd_slv - DSO-side end of the host UART command link (8N1, LSB first,
// idle high). Three received bytes form a 24-bit command that is handed to the
// command processor with a ready/clear handshake. Single response bytes (ack,
// nak, read data) are serialised back to the host. RX and TX run independently.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   RX           serial in from host (asynchronous, synchronised here)
//   TX           serial out to host
//   cmd          assembled command: byte0 [23:16], byte1 [15:8], byte2 [7:0]
//   cmd_rdy      full command valid, held until cleared
//   clr_cmd_rdy  consumer clears cmd_rdy
//   resp         response byte
//   send_resp    request to transmit resp
//   tx_busy      transmitter active
//   resp_sent    1-cycle pulse when the stop bit of resp completes
//   err          1-cycle pulse on framing error, inter-byte timeout or overrun
module uart_cmd_slv #(
  parameter int BAUD_DIV = 434,
  parameter int TMO_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        err
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TMO_BITS * BAUD_DIV + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_BITS * BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- RX path
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_arm;
  logic [1:0]    rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    byte0, byte1;
  logic [1:0]    idx;
  logic [TW-1:0] tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_arm   <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      byte0    <= '0;
      byte1    <= '0;
      idx      <= '0;
      tmo      <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      err      <= 1'b0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      err     <= 1'b0;

      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;

      if (rx_state != S_IDLE)
        tmo <= '0;

      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          // After a framing error the line must be seen high before a new
          // falling edge is trusted as a start bit.
          if (!rx_arm) begin
            if (rx_s2)
              rx_arm <= 1'b1;
          end else if (rx_prev && !rx_s2) begin
            rx_state <= S_START;
          end

          if (idx == 2'd0) begin
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            idx <= 2'd0;
            tmo <= '0;
            err <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            // Line back high at mid-start: treat as a glitch, silently.
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        S_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7)
              rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        S_STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (!rx_s2) begin
              err    <= 1'b1;
              idx    <= 2'd0;
              rx_arm <= 1'b0;
            end else if (cmd_rdy) begin
              // Overrun: previous command not yet consumed; byte dropped.
              err <= 1'b1;
            end else begin
              case (idx)
                2'd0: begin
                  byte0 <= rx_sh;
                  idx   <= 2'd1;
                end
                2'd1: begin
                  byte1 <= rx_sh;
                  idx   <= 2'd2;
                end
                default: begin
                  cmd     <= {byte0, byte1, rx_sh};
                  cmd_rdy <= 1'b1;
                  idx     <= 2'd0;
                end
              endcase
            end
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end

        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX path
  logic [1:0]    tx_state;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
    end else begin
      resp_sent <= 1'b0;

      case (tx_state)
        S_IDLE: begin
          if (send_resp) begin
            tx_sh    <= resp;
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end

        S_START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TX       <= tx_sh[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end

        S_DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              TX       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              TX     <= tx_sh[tx_bit + 3'd1];
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end

        S_STOP: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt    <= '0;
            resp_sent <= 1'b1;
            // A request arriving on the last stop cycle chains straight into
            // the next start bit without an idle gap.
            if (send_resp) begin
              tx_sh    <= resp;
              TX       <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_busy  <= 1'b0;
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end

        default: tx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_slv.sv
module tb_uart_cmd_slv;

  localparam int BAUD = 16;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  int last_c0  = 0;
  logic rdy_q  = 1'b0;

  uart_cmd_slv #(.BAUD_DIV(BAUD), .TMO_BITS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (cmd_rdy === 1'b1 && rdy_q !== 1'b1) rise_cyc = cyc;
    rdy_q = cmd_rdy;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Host-side serialiser: start, 8 data LSB first, stop (value given).
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = fr[i];
      if (i == 0) last_c0 = cyc;
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic clear_rdy();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_TX got %b want 1", TX); end
    n_checks++; if (cmd !== 24'h0) begin n_fail++; $display("FAIL reset_cmd got %h want 000000", cmd); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_rdy got %b want 0", cmd_rdy); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
    n_checks++; if (resp_sent !== 1'b0) begin n_fail++; $display("FAIL reset_resp_sent got %b want 0", resp_sent); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_assembly();
    int e0, c;
    e0 = err_cnt;
    rise_cyc = -1;
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    c = last_c0;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd !== 24'h021300) begin n_fail++; $display("FAIL asm_cmd got %h want 021300", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL asm_cmd_rdy got %b want 1", cmd_rdy); end
    n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL asm_no_err got %0d err pulses want 0", err_cnt - e0); end
    // Stop bit of the 3rd byte occupies cycles c+144..c+160; ready must rise inside it.
    n_checks++;
    if (rise_cyc < c + 145 || rise_cyc > c + 160) begin
      n_fail++; $display("FAIL asm_rdy_timing got cycle offset %0d want within 145..160", rise_cyc - c);
    end
  endtask

  task automatic test_overrun_and_clear();
    int e0;
    e0 = err_cnt;
    send_byte(8'h05, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL ovr_err got %0d pulses want 1", err_cnt - e0); end
    n_checks++; if (cmd !== 24'h021300) begin n_fail++; $display("FAIL ovr_cmd_frozen got %h want 021300", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ovr_rdy_held got %b want 1", cmd_rdy); end
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL clr_rdy got %b want 0", cmd_rdy); end
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL clr_rdy_stays got %b want 0", cmd_rdy); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_byte(8'h08, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (80) @(negedge clk);
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL tmo_err got %0d pulses want 1", err_cnt - e0); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL tmo_no_rdy got %b want 0", cmd_rdy); end
    send_byte(8'h06, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (cmd !== 24'h060102) begin n_fail++; $display("FAIL tmo_cmd got %h want 060102", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL tmo_cmd_rdy got %b want 1", cmd_rdy); end
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL tmo_extra_err got %0d pulses want 1", err_cnt - e0); end
    clear_rdy();
  endtask

  task automatic test_framing();
    int e0;
    e0 = err_cnt;
    send_byte(8'h03, 1'b0);
    @(negedge clk);
    RX = 1'b1;
    repeat (16) @(negedge clk);
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL frm_err got %0d pulses want 1", err_cnt - e0); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL frm_no_rdy got %b want 0", cmd_rdy); end
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3F, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (cmd !== 24'h03003F) begin n_fail++; $display("FAIL frm_cmd got %h want 03003f", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL frm_cmd_rdy got %b want 1", cmd_rdy); end
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL frm_extra_err got %0d pulses want 1", err_cnt - e0); end
    clear_rdy();
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    @(negedge clk);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    // Long enough for a phantom byte plus the inter-byte timeout to show up.
    repeat (250) @(negedge clk);
    n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_err got %0d pulses want 0", err_cnt - e0); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy got %b want 0", cmd_rdy); end
  endtask

  task automatic test_tx();
    logic [9:0] fr;
    logic [9:0] seen;
    fr = {1'b1, 8'hA5, 1'b0};
    seen = '0;
    n_checks++; if (tx_busy !== 1'b0 || TX !== 1'b1) begin n_fail++; $display("FAIL tx_idle got busy=%b TX=%b want 0/1", tx_busy, TX); end
    @(negedge clk);
    resp = 8'hA5;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int n = 0; n <= 161; n++) begin
      if (n == 50) begin
        resp = 8'h5A;
        send_resp = 1'b1;
      end else if (n == 51) begin
        send_resp = 1'b0;
      end
      if (n == 0) begin
        n_checks++; if (TX !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_start got TX=%b busy=%b want 0/1", TX, tx_busy); end
      end
      if (n < 160 && n % 16 == 8) begin
        seen[n / 16] = TX;
        n_checks++; if (TX !== fr[n / 16]) begin n_fail++; $display("FAIL tx_bit%0d got %b want %b", n / 16, TX, fr[n / 16]); end
      end
      if (n == 159) begin
        n_checks++; if (resp_sent !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_pre_end got sent=%b busy=%b want 0/1", resp_sent, tx_busy); end
      end
      if (n == 160) begin
        n_checks++; if (resp_sent !== 1'b1) begin n_fail++; $display("FAIL tx_resp_sent got %b want 1", resp_sent); end
        n_checks++; if (tx_busy !== 1'b0 || TX !== 1'b1) begin n_fail++; $display("FAIL tx_end got busy=%b TX=%b want 0/1", tx_busy, TX); end
      end
      if (n == 161) begin
        n_checks++; if (resp_sent !== 1'b0) begin n_fail++; $display("FAIL tx_sent_pulse got %b want 0", resp_sent); end
      end
      @(negedge clk);
    end
    n_checks++; if (seen[8:1] !== 8'hA5) begin n_fail++; $display("FAIL tx_ref_byte got %h want a5", seen[8:1]); end
  endtask

  task automatic test_tx_reset();
    @(negedge clk);
    resp = 8'h00;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if (TX !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL txrst_pre got TX=%b busy=%b want 0/1", TX, tx_busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL txrst_TX got %b want 1", TX); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL txrst_busy got %b want 0", tx_busy); end
    n_checks++; if (cmd !== 24'h0) begin n_fail++; $display("FAIL txrst_cmd got %h want 000000", cmd); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    RX          = 1'b1;
    rst         = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    resp        = 8'h00;
    test_reset();
    test_cmd_assembly();
    test_overrun_and_clear();
    test_timeout();
    test_framing();
    test_glitch();
    test_tx();
    test_tx_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
